// File: rtl/softmax_seq.sv
`default_nettype none
// ============================================================================
//  Module   : softmax_seq
//  Purpose  : Collects the serial FC2 activations and the sample label, tracks
//             the signed running maximum, starts the softmax unit, then turns
//             its probabilities into the cross-entropy gradient
//             softmax(z) - onehot(label), held under a valid/ready handshake.
//  Option   : SOFTMAX_ARGMAX_EN adds argmax tracking (pred_o / correct_o).
//  Revision : 1.0 - initial release
// ============================================================================
module softmax_seq #(
    parameter int N_NEURONS = 10,
    parameter int PREC      = 16,
    parameter int FRAC      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      act_valid_i,
    input  logic [PREC-1:0]           act_i,
    input  logic [3:0]                label_i,
    output logic                      act_ready_o,
    output logic                      sm_start_o,
    output logic [PREC-1:0]           sm_max_o,
    output logic [N_NEURONS*PREC-1:0] sm_act_o,
    input  logic                      sm_valid_i,
    input  logic [N_NEURONS*PREC-1:0] sm_grad_i,
    output logic                      grad_valid_o,
    input  logic                      grad_ready_i,
    output logic [N_NEURONS*PREC-1:0] grad_o,
    output logic                      busy_o,
    output logic [3:0]                pred_o,
    output logic                      correct_o
);

    localparam logic [PREC-1:0] c_ONE  = {{(PREC-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [3:0]      c_LAST = 4'(N_NEURONS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q;
    logic [3:0]      label_q;
    logic [PREC-1:0] max_q;
    logic [PREC-1:0] act_q      [N_NEURONS];
    logic [PREC-1:0] grad_q     [N_NEURONS];
    logic [PREC-1:0] w_grad_cap [N_NEURONS];

    logic       w_accept;
    logic       w_last_accept;
    logic       w_gt;
    logic [3:0] w_wr_idx;

    assign w_accept      = act_valid_i && (state_q == ST_IDLE || state_q == ST_COLLECT);
    assign w_last_accept = w_accept && (state_q == ST_COLLECT) && (idx_q == c_LAST);
    assign w_gt          = $signed(act_i) > $signed(max_q);
    // The first word of a sample always lands at slot 0.
    assign w_wr_idx      = (state_q == ST_IDLE) ? 4'd0 : idx_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d      = state_q;
        act_ready_o  = 1'b0;
        sm_start_o   = 1'b0;
        grad_valid_o = 1'b0;
        busy_o       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                act_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (w_accept) begin
                    state_d = (N_NEURONS <= 1) ? ST_START : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                act_ready_o = 1'b1;
                if (w_last_accept) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                sm_start_o = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (sm_valid_i) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                grad_valid_o = 1'b1;
                if (grad_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Activation vector, running max, label and gradient capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= 4'd0;
            label_q <= 4'd0;
            max_q   <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                act_q[i]  <= '0;
                grad_q[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                for (int i = 0; i < N_NEURONS; i++) begin
                    if (w_wr_idx == 4'(i)) begin
                        act_q[i] <= act_i;
                    end
                end
                if (state_q == ST_IDLE) begin
                    max_q   <= act_i;
                    label_q <= label_i;
                    idx_q   <= 4'd1;
                end else begin
                    // Strict compare: ties keep the earlier value.
                    if (w_gt) begin
                        max_q <= act_i;
                    end
                    idx_q <= (idx_q == c_LAST) ? 4'd0 : idx_q + 4'd1;
                end
            end
            if (state_q == ST_WAIT && sm_valid_i) begin
                for (int i = 0; i < N_NEURONS; i++) begin
                    grad_q[i] <= w_grad_cap[i];
                end
            end
        end
    end

    // Per-lane gradient: subtract ONE only in the label lane; labels outside
    // the vector match no lane and pass the probabilities through unchanged.
    generate
        for (genvar i = 0; i < N_NEURONS; i++) begin : g_lane
            localparam logic [3:0] c_IDX = 4'(i);
            logic [PREC-1:0] w_lane;
            assign w_lane                    = sm_grad_i[i*PREC +: PREC];
            assign w_grad_cap[i]             = (label_q == c_IDX) ? (w_lane - c_ONE) : w_lane;
            assign sm_act_o[i*PREC +: PREC]  = act_q[i];
            assign grad_o[i*PREC +: PREC]    = grad_q[i];
        end
    endgenerate

    assign sm_max_o = max_q;

`ifdef SOFTMAX_ARGMAX_EN
    logic [3:0] arg_q;
    logic [3:0] pred_q;
    logic       correct_q;
    logic [3:0] w_arg_nxt;

    assign w_arg_nxt = (state_q == ST_IDLE) ? 4'd0 : (w_gt ? idx_q : arg_q);

    // Argmax follows the max; the prediction is published with the start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arg_q     <= 4'd0;
            pred_q    <= 4'd0;
            correct_q <= 1'b0;
        end else begin
            if (w_accept) begin
                arg_q <= w_arg_nxt;
            end
            if (w_last_accept) begin
                pred_q    <= w_arg_nxt;
                correct_q <= (w_arg_nxt == label_q);
            end
        end
    end

    assign pred_o    = pred_q;
    assign correct_o = correct_q;
`else
    assign pred_o    = 4'd0;
    assign correct_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_softmax_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_softmax_seq
//  Purpose  : Directed self-checking bench for softmax_seq with a behavioural
//             reference model of max / argmax / gradient.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_seq;
    localparam int N = 10;
    localparam int P = 16;
    localparam int F = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             act_valid_i = 1'b0;
    logic [P-1:0]     act_i = '0;
    logic [3:0]       label_i = '0;
    logic             act_ready_o;
    logic             sm_start_o;
    logic [P-1:0]     sm_max_o;
    logic [N*P-1:0]   sm_act_o;
    logic             sm_valid_i = 1'b0;
    logic [N*P-1:0]   sm_grad_i = '0;
    logic             grad_valid_o;
    logic             grad_ready_i = 1'b0;
    logic [N*P-1:0]   grad_o;
    logic             busy_o;
    logic [3:0]       pred_o;
    logic             correct_o;

    softmax_seq #(.N_NEURONS(N), .PREC(P), .FRAC(F)) dut (
        .clk(clk), .reset(reset),
        .act_valid_i(act_valid_i), .act_i(act_i), .label_i(label_i),
        .act_ready_o(act_ready_o), .sm_start_o(sm_start_o),
        .sm_max_o(sm_max_o), .sm_act_o(sm_act_o),
        .sm_valid_i(sm_valid_i), .sm_grad_i(sm_grad_i),
        .grad_valid_o(grad_valid_o), .grad_ready_i(grad_ready_i),
        .grad_o(grad_o), .busy_o(busy_o), .pred_o(pred_o), .correct_o(correct_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [N*P-1:0] got, input logic [N*P-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [P-1:0]   m_act [N];
    logic [P-1:0]   m_sm  [N];
    int             m_label;
    logic [P-1:0]   e_max;
    int             e_pred;
    logic           e_corr;
    logic [N*P-1:0] e_actv;
    logic [N*P-1:0] e_grad;

    function automatic logic [N*P-1:0] pack(input logic [P-1:0] a [N]);
        logic [N*P-1:0] v;
        for (int i = 0; i < N; i++) v[i*P +: P] = a[i];
        return v;
    endfunction

    task automatic model();
        int best;
        int v;
        best   = $signed(m_act[0]);
        e_pred = 0;
        for (int i = 1; i < N; i++) begin
            if ($signed(m_act[i]) > best) begin
                best   = $signed(m_act[i]);
                e_pred = i;
            end
        end
        e_max  = 16'(best);
        e_corr = (e_pred == m_label);
        e_actv = pack(m_act);
        for (int i = 0; i < N; i++) begin
            v = $signed(m_sm[i]);
            if (i == m_label) v = v - (1 << F);
            e_grad[i*P +: P] = 16'(v);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (reset) begin
            if (sm_start_o) begin
                chk("start_max", sm_max_o, e_max);
                chk("start_vec", sm_act_o, e_actv);
`ifdef SOFTMAX_ARGMAX_EN
                chk("start_pred", pred_o, 4'(e_pred));
                chk("start_correct", correct_o, e_corr);
`else
                chk("pred_tied", pred_o, 4'd0);
                chk("correct_tied", correct_o, 1'b0);
`endif
            end
            if (grad_valid_o) chk("grad_vec", grad_o, e_grad);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, act_ready_o, 1'b1);
        chk({tag, "_start"}, sm_start_o, 1'b0);
        chk({tag, "_gvalid"}, grad_valid_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_max"}, sm_max_o, '0);
        chk({tag, "_act"}, sm_act_o, '0);
        chk({tag, "_grad"}, grad_o, '0);
        chk({tag, "_pred"}, pred_o, 4'd0);
        chk({tag, "_correct"}, correct_o, 1'b0);
    endtask

    task automatic send_vec(input bit gap);
        for (int k = 0; k < N; k++) begin
            if (gap) begin
                act_valid_i = 1'b0;
                cyc();
                chk("gap_no_start", sm_start_o, 1'b0);
            end
            act_valid_i = 1'b1;
            act_i       = m_act[k];
            label_i     = (k == 0) ? 4'(m_label) : 4'hF;
            chk("act_ready", act_ready_o, 1'b1);
            cyc();
            if (k < N - 1) chk("no_early_start", sm_start_o, 1'b0);
        end
        act_valid_i = 1'b0;
        chk("start_after_last", sm_start_o, 1'b1);
    endtask

    // hold: cycles sm_valid_i stays high; nv: cycles grad_valid_o is high.
    task automatic finish_sample(input int hold, input int nv);
        cyc();
        chk("start_one_cycle", sm_start_o, 1'b0);
        chk("wait_busy", busy_o, 1'b1);
        chk("wait_not_ready", act_ready_o, 1'b0);
        cyc();
        cyc();
        chk("wait_no_gvalid", grad_valid_o, 1'b0);
        sm_valid_i   = 1'b1;
        sm_grad_i    = pack(m_sm);
        grad_ready_i = (nv == 1);
        cyc();
        for (int c = 1; c <= nv; c++) begin
            chk("gvalid_high", grad_valid_o, 1'b1);
            sm_valid_i   = (c < hold);
            sm_grad_i    = {N{16'h7777}};
            grad_ready_i = (c == nv);
            cyc();
        end
        sm_valid_i   = 1'b0;
        grad_ready_i = 1'b0;
        chk("post_hs_gvalid", grad_valid_o, 1'b0);
        chk("post_hs_ready", act_ready_o, 1'b1);
        chk("post_hs_busy", busy_o, 1'b0);
    endtask

    task automatic run(input bit gap, input int hold, input int nv);
        model();
        send_vec(gap);
        finish_sample(hold, nv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int t2 [N];
        int t3 [N];
        t2 = '{-5, -3, -3, -7, -10, -4, -20, -3, -100, -6};
        t3 = '{100, -200, 50, 300, 7, 300, -1, 0, 2, 299};

        #2;
        chk_reset("por");
        @(negedge clk);
        reset = 1'b1;
        cyc();

        // T1: ramp, label 3, uniform probabilities, ready already high
        for (int i = 0; i < N; i++) begin
            m_act[i] = 16'(16 * i);
            m_sm[i]  = 16'h0019;
        end
        m_label = 3;
        run(1'b0, 1, 1);
        chk("t1_max_lit", sm_max_o, 16'd144);
        chk("t1_grad3_lit", grad_o[3*P +: P], 16'hFF19);
        chk("t1_grad0_lit", grad_o[0 +: P], 16'h0019);
        chk("t1_grad9_lit", grad_o[9*P +: P], 16'h0019);
`ifdef SOFTMAX_ARGMAX_EN
        chk("t1_pred_lit", pred_o, 4'd9);
        chk("t1_correct_lit", correct_o, 1'b0);
`endif

        // T2: negatives with ties, back-to-back with T1
        for (int i = 0; i < N; i++) begin
            m_act[i] = 16'(t2[i]);
            m_sm[i]  = 16'(20 * i + 5);
        end
        m_label = 1;
        run(1'b0, 1, 1);
        chk("t2_max_lit", sm_max_o, 16'hFFFD);
        chk("t2_grad1_lit", grad_o[1*P +: P], 16'hFF19);
`ifdef SOFTMAX_ARGMAX_EN
        chk("t2_pred_lit", pred_o, 4'd1);
        chk("t2_correct_lit", correct_o, 1'b1);
`endif

        // T3: gapped activations
        for (int i = 0; i < N; i++) begin
            m_act[i] = 16'(t3[i]);
            m_sm[i]  = 16'(i * 9 + 1);
        end
        m_label = 9;
        run(1'b1, 1, 1);
        chk("t3_max_lit", sm_max_o, 16'd300);

        // T4: softmax valid held two cycles, consumer stalls five cycles
        for (int i = 0; i < N; i++) begin
            m_act[i] = 16'(7 * i - 30);
            m_sm[i]  = 16'(16 * i + 3);
        end
        m_label = 0;
        run(1'b0, 2, 5);
        chk("t4_grad0_lit", grad_o[0 +: P], 16'hFF03);

        // T5a: reset in COLLECT after four words
        for (int i = 0; i < 4; i++) begin
            act_valid_i = 1'b1;
            act_i       = 16'(i + 1);
            label_i     = 4'd2;
            cyc();
        end
        act_valid_i = 1'b0;
        #3 reset = 1'b0;
        #1 chk_reset("rst_collect");
        @(negedge clk);
        reset = 1'b1;
        cyc();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 16'(50 - 3 * i);
            m_sm[i]  = 16'(i + 40);
        end
        m_label = 5;
        run(1'b0, 1, 2);
        chk("t5a_grad5_lit", grad_o[5*P +: P], 16'hFF2D);

        // T5b: reset in WAIT, stray softmax pulse afterwards
        model();
        send_vec(1'b0);
        cyc();
        cyc();
        chk("t5b_in_wait", busy_o, 1'b1);
        #2 reset = 1'b0;
        #1 chk_reset("rst_wait");
        @(negedge clk);
        reset = 1'b1;
        cyc();
        sm_valid_i = 1'b1;
        sm_grad_i  = {N{16'h0042}};
        cyc();
        sm_valid_i = 1'b0;
        chk("stray_gvalid", grad_valid_o, 1'b0);
        chk("stray_busy", busy_o, 1'b0);
        chk("stray_grad", grad_o, '0);
        for (int i = 0; i < N; i++) begin
            m_act[i] = 16'(i * i);
            m_sm[i]  = 16'(25);
        end
        m_label = 4;
        run(1'b0, 1, 1);
        chk("t5b_grad4_lit", grad_o[4*P +: P], 16'hFF19);

        // T6: label outside the vector passes probabilities through
        for (int i = 0; i < N; i++) begin
            m_act[i] = 16'(i * 11);
            m_sm[i]  = 16'(i * 13 + 2);
        end
        m_label = 12;
        run(1'b0, 1, 1);
        chk("t6_passthru", grad_o, pack(m_sm));
        chk("t6_correct", correct_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
